// File: rtl/noc_pkg.sv
// noc_pkg: shared constants, port enumeration, packet type and index helper
// for the NoC output-port arbiter (noc_port_arbiter).
package noc_pkg;

   localparam int WIDTH_PACKET = 57;
   localparam int NUM_PORTS    = 5;
   localparam int IDX_W        = 3;

   typedef enum logic [2:0] {
      N  = 3'd0,
      S  = 3'd1,
      E  = 3'd2,
      W  = 3'd3,
      PE = 3'd4
   } port_e;

   typedef logic [WIDTH_PACKET-1:0] packet_t;

   // Next port index in round-robin order, wrapping from the last port to 0.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] nxt;
      if (idx >= IDX_W'(NUM_PORTS - 1)) begin
         nxt = {IDX_W{1'b0}};
      end else begin
         nxt = idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

endpackage

// File: rtl/noc_port_arbiter_rr_picker.sv
// rr_picker: combinational rotate-priority-rotate round-robin picker.
// Requests are rotated so that index ptr sits at position 0, the lowest set
// bit wins, and the winning offset is rotated back to a real port index.
// ptr is expected to be below NP.
module rr_picker
   import noc_pkg::*;
#(
   parameter int NP = NUM_PORTS
) (
   input  logic [NP-1:0]    req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NP-1:0]    gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [NP-1:0]    rot_s;
   logic [IDX_W-1:0] off_s;
   logic [IDX_W:0]   sum_s;

   // Rotate, pick lowest set bit, rotate the offset back to a port index.
   always_comb begin
      rot_s = {NP{1'b0}};
      off_s = {IDX_W{1'b0}};
      for (int k = 0; k < NP; k++) begin
         rot_s[k] = req[((int'(ptr) + k) >= NP) ? (int'(ptr) + k - NP) : (int'(ptr) + k)];
      end
      for (int k = NP - 1; k >= 0; k--) begin
         off_s = rot_s[k] ? IDX_W'(k) : off_s;
      end
      any   = |rot_s;
      sum_s = {1'b0, ptr} + {1'b0, off_s};
      idx   = (sum_s >= (IDX_W+1)'(NP)) ? IDX_W'(sum_s - (IDX_W+1)'(NP)) : sum_s[IDX_W-1:0];
      gnt   = any ? ({{(NP-1){1'b0}}, 1'b1} << idx) : {NP{1'b0}};
   end

endmodule

// File: rtl/noc_port_arbiter.sv
// noc_port_arbiter: round-robin arbiter sharing one output link among the
// five router inputs, with a one-entry registered output stage.
// Optional feature macro: NOC_ARB_STATS_EN adds saturating per-port grant
// counters on the grant_cnt port.
module noc_port_arbiter #(
   parameter int WIDTH_PACKET = noc_pkg::WIDTH_PACKET,
   parameter int NUM_PORTS    = noc_pkg::NUM_PORTS,
   parameter int CNT_W        = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_PORTS-1:0]              req_valid,
   input  logic [NUM_PORTS*WIDTH_PACKET-1:0] req_data,
   output logic [NUM_PORTS-1:0]              req_ready,
   output logic                              out_valid,
   output logic [WIDTH_PACKET-1:0]           out_data,
   output logic [2:0]                        out_src,
   input  logic                              out_ready
`ifdef NOC_ARB_STATS_EN
   ,
   output logic [NUM_PORTS*CNT_W-1:0]        grant_cnt
`endif
);

   logic [NUM_PORTS-1:0]    gnt_s;
   logic [2:0]              win_s;
   logic                    any_s;
   logic                    load_s;
   logic [WIDTH_PACKET-1:0] win_data_s;

   logic                    out_valid_r;
   logic [WIDTH_PACKET-1:0] out_data_r;
   logic [2:0]              out_src_r;
   logic [2:0]              ptr_r;

   rr_picker #(.NP(NUM_PORTS)) u_picker (
      .req (req_valid),
      .ptr (ptr_r),
      .gnt (gnt_s),
      .idx (win_s),
      .any (any_s)
   );

   // A packet is taken whenever someone requests and the output stage is free
   // or draining this cycle; nothing is accepted while reset is asserted.
   assign load_s = any_s & (~out_valid_r | out_ready) & rst_n;

   // Accept strobe and winning packet (AND-OR mux over the one-hot grant).
   always_comb begin
      req_ready  = gnt_s & {NUM_PORTS{load_s}};
      win_data_s = {WIDTH_PACKET{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
         win_data_s = win_data_s | (req_data[i*WIDTH_PACKET +: WIDTH_PACKET] & {WIDTH_PACKET{gnt_s[i]}});
      end
   end

   // Output stage and round-robin pointer; a new load replaces a drained packet
   // on the same edge, backpressure holds the stage untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {WIDTH_PACKET{1'b0}};
         out_src_r   <= 3'd0;
         ptr_r       <= 3'd0;
      end else if (load_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= win_data_s;
         out_src_r   <= win_s;
         ptr_r       <= noc_pkg::next_idx(win_s);
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_src   = out_src_r;

`ifdef NOC_ARB_STATS_EN
   logic [NUM_PORTS*CNT_W-1:0] cnt_r;

   // Per-port grant counters: saturate at all-ones, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {(NUM_PORTS*CNT_W){1'b0}};
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (load_s && gnt_s[i] && (cnt_r[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
               cnt_r[i*CNT_W +: CNT_W] <= cnt_r[i*CNT_W +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign grant_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb_noc_port_arbiter: scenario tasks plus a cycle monitor holding a
// behavioural round-robin model and a scoreboard queue of expected packets.
// Build with NOC_ARB_STATS_EN defined to include the grant-counter scenario.
module tb_noc_port_arbiter;

   localparam int WP = 57;
   localparam int NP = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NP-1:0]   req_valid = '0;
   logic [NP*WP-1:0] req_data = '0;
   logic [NP-1:0]   req_ready;
   logic            out_valid;
   logic [WP-1:0]   out_data;
   logic [2:0]      out_src;
   logic            out_ready = 1'b0;

   int tests_run = 0;
   int failed    = 0;

`ifdef NOC_ARB_STATS_EN
   localparam int CW = 4;
   logic [NP*CW-1:0] grant_cnt;

   noc_port_arbiter #(.CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
      .out_src(out_src), .out_ready(out_ready), .grant_cnt(grant_cnt)
   );
`else
   noc_port_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
      .out_src(out_src), .out_ready(out_ready)
   );
`endif

   always #5 clk = ~clk;

   // Reference model state and scoreboard of {src, data} expected at the output.
   logic [2:0]  m_ptr  = 3'd0;
   logic        m_full = 1'b0;
   logic [59:0] sb_q[$];

   // Monitor: predict accept strobes, check the output stage, advance the model.
   always @(negedge clk) begin : mon
      logic          found;
      int            w;
      int            idx;
      logic [NP-1:0] er;
      logic [59:0]   head;
      found = 1'b0;
      w     = 0;
      er    = '0;
      if (rst_n && (|req_valid) && (!m_full || out_ready)) begin
         for (int k = 0; k < NP; k++) begin
            idx = (int'(m_ptr) + k) % NP;
            if (!found && req_valid[idx]) begin
               found = 1'b1;
               w     = idx;
            end
         end
         er[w] = 1'b1;
      end
      tests_run++;
      if (req_ready !== er) begin
         failed++;
         $display("FAIL mon_ready t=%0t got %b exp %b", $time, req_ready, er);
      end
      tests_run++;
      if (out_valid !== m_full) begin
         failed++;
         $display("FAIL mon_out_valid t=%0t got %b exp %b", $time, out_valid, m_full);
      end
      tests_run++;
      if (dut.ptr_r !== m_ptr) begin
         failed++;
         $display("FAIL mon_ptr t=%0t got %0d exp %0d", $time, dut.ptr_r, m_ptr);
      end
      if (m_full) begin
         tests_run++;
         if (sb_q.size() == 0) begin
            failed++;
            $display("FAIL mon_scoreboard_empty t=%0t got packet src %0d exp none", $time, out_src);
         end else begin
            head = sb_q[0];
            if ({out_src, out_data} !== head) begin
               failed++;
               $display("FAIL mon_out_pkt t=%0t got src %0d data %h exp src %0d data %h",
                        $time, out_src, out_data, head[59:57], head[56:0]);
            end
         end
      end
      if (!rst_n) begin
         m_full = 1'b0;
         m_ptr  = 3'd0;
         sb_q.delete();
      end else begin
         if (m_full && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
         if (found) begin
            sb_q.push_back({3'(w), req_data[w*WP +: WP]});
            m_full = 1'b1;
            m_ptr  = 3'((w + 1) % NP);
         end else if (out_ready) begin
            m_full = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int p, input logic [WP-1:0] d);
      req_data[p*WP +: WP] = d;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 5'b11111;
      out_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      tests_run++;
      if (req_ready !== 5'b00000) begin failed++; $display("FAIL reset_ready got %b exp 00000", req_ready); end
      tests_run++;
      if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests_run++;
      if (out_data !== 57'd0) begin failed++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      tests_run++;
      if (out_src !== 3'd0) begin failed++; $display("FAIL reset_out_src got %0d exp 0", out_src); end
      tests_run++;
      if (dut.ptr_r !== 3'd0) begin failed++; $display("FAIL reset_ptr got %0d exp 0", dut.ptr_r); end
`ifdef NOC_ARB_STATS_EN
      tests_run++;
      if (grant_cnt !== '0) begin failed++; $display("FAIL reset_grant_cnt got %h exp 0", grant_cnt); end
`endif
      tick();
      rst_n     = 1'b1;
      req_valid = '0;
   endtask

   task automatic test_single();
      set_data(2, 57'h1ABC);
      req_valid = 5'b00100;
      out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (req_ready !== 5'b00100) begin failed++; $display("FAIL single_ready got %b exp 00100", req_ready); end
      tick();
      req_valid = '0;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 57'h1ABC || out_src !== 3'd2) begin
         failed++;
         $display("FAIL single_out got v%b %h src %0d exp v1 1abc src 2", out_valid, out_data, out_src);
      end
      tests_run++;
      if (dut.ptr_r !== 3'd3) begin failed++; $display("FAIL single_ptr got %0d exp 3", dut.ptr_r); end
      tick();
   endtask

   task automatic test_round_robin();
      logic [NP-1:0] rdy;
      logic [2:0]    e;
      do_reset();
      out_ready = 1'b1;
      for (int p = 0; p < NP; p++) set_data(p, 57'(64'h100 + p));
      req_valid = 5'b11111;
      for (int k = 0; k < 8; k++) begin
         if (k == 7) req_valid = '0;
         @(negedge clk);
         if (k > 0) begin
            e = 3'((k - 1) % NP);
            tests_run++;
            if (out_valid !== 1'b1 || out_src !== e) begin
               failed++;
               $display("FAIL rr_seq step %0d got v%b src %0d exp v1 src %0d", k, out_valid, out_src, e);
            end
         end
         rdy = req_ready;
         tick();
         for (int p = 0; p < NP; p++) if (rdy[p]) set_data(p, 57'(64'h200 + k * 16 + p));
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [WP-1:0] d1;
      d1 = 57'h0AA_5555_1234;
      do_reset();
      out_ready = 1'b0;
      set_data(1, d1);
      req_valid = 5'b00010;
      tick();
      set_data(0, 57'h0F0);
      set_data(3, 57'h333);
      req_valid = 5'b01001;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         tests_run++;
         if (req_ready !== 5'b00000) begin failed++; $display("FAIL bp_ready cyc %0d got %b exp 00000", c, req_ready); end
         tests_run++;
         if (out_valid !== 1'b1 || out_data !== d1 || out_src !== 3'd1) begin
            failed++;
            $display("FAIL bp_hold cyc %0d got v%b %h src %0d exp v1 %h src 1", c, out_valid, out_data, out_src, d1);
         end
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (req_ready !== 5'b01000) begin failed++; $display("FAIL bp_release_ready got %b exp 01000", req_ready); end
      tick();
      req_valid = 5'b00001;
      @(negedge clk);
      tests_run++;
      if (out_src !== 3'd3 || req_ready !== 5'b00001) begin
         failed++;
         $display("FAIL bp_next got src %0d ready %b exp src 3 ready 00001", out_src, req_ready);
      end
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      out_ready = 1'b1;
      set_data(3, 57'h3);
      req_valid = 5'b01000;
      tick();
      set_data(0, 57'hA0);
      set_data(1, 57'hA1);
      req_valid = 5'b00011;
      @(negedge clk);
      tests_run++;
      if (dut.ptr_r !== 3'd4 || req_ready !== 5'b00001) begin
         failed++;
         $display("FAIL wrap_grant got ptr %0d ready %b exp ptr 4 ready 00001", dut.ptr_r, req_ready);
      end
      tick();
      req_valid = 5'b00010;
      @(negedge clk);
      tests_run++;
      if (dut.ptr_r !== 3'd1 || out_src !== 3'd0) begin
         failed++;
         $display("FAIL wrap_ptr got ptr %0d src %0d exp ptr 1 src 0", dut.ptr_r, out_src);
      end
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      set_data(2, 57'h1_2345_6789);
      req_valid = 5'b00100;
      tick();
      req_valid = '0;
      tick();
      rst_n     = 1'b0;
      req_valid = 5'b00100;
      @(negedge clk);
      tests_run++;
      if (req_ready !== 5'b00000) begin failed++; $display("FAIL mid_rst_ready got %b exp 00000", req_ready); end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0 || dut.ptr_r !== 3'd0) begin
         failed++;
         $display("FAIL mid_rst_state got v%b ptr %0d exp v0 ptr 0", out_valid, dut.ptr_r);
      end
      tests_run++;
      if (req_ready !== 5'b00100) begin failed++; $display("FAIL mid_rst_regrant got %b exp 00100", req_ready); end
      tick();
      req_valid = '0;
      out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 57'h1_2345_6789 || out_src !== 3'd2) begin
         failed++;
         $display("FAIL mid_rst_out got v%b %h src %0d exp v1 123456789 src 2", out_valid, out_data, out_src);
      end
      tick();
   endtask

   task automatic test_random();
      logic [NP-1:0] rdy;
      logic [63:0]   r;
      int            waits[NP];
      for (int p = 0; p < NP; p++) waits[p] = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rdy = req_ready;
         if (|rdy) begin
            for (int p = 0; p < NP; p++) begin
               if (req_valid[p] && !rdy[p]) begin
                  waits[p]++;
                  tests_run++;
                  if (waits[p] > NP - 1) begin
                     failed++;
                     $display("FAIL fairness port %0d got %0d foreign loads exp <= %0d", p, waits[p], NP - 1);
                  end
               end else begin
                  waits[p] = 0;
               end
            end
         end
         tick();
         for (int p = 0; p < NP; p++) begin
            if (rdy[p] || !req_valid[p]) begin
               r = {$urandom, $urandom};
               set_data(p, r[WP-1:0]);
               req_valid[p] = ($urandom_range(0, 2) != 0);
               waits[p] = 0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      req_valid = '0;
      out_ready = 1'b1;
      tick();
      tick();
   endtask

`ifdef NOC_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      out_ready = 1'b1;
      set_data(4, 57'h44);
      req_valid = 5'b10000;
      repeat (20) tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      tests_run++;
      if (grant_cnt[4*CW +: CW] !== 4'd15) begin
         failed++;
         $display("FAIL stats_sat got %0d exp 15", grant_cnt[4*CW +: CW]);
      end
      tests_run++;
      if (grant_cnt[4*CW-1:0] !== 16'd0) begin
         failed++;
         $display("FAIL stats_others got %h exp 0", grant_cnt[4*CW-1:0]);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_random();
`ifdef NOC_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule

// File: doc/noc_port_arbiter.md
# noc_port_arbiter

Clocked output-port arbiter for one direction of a mesh router. It shares a single 57-bit output link among the five router inputs (N, S, E, W, PE) using round-robin priority, and registers the winning packet in a one-entry output stage. One instance sits in front of each router output port. It serialises contention at the output so no packet is lost or duplicated.

## Interface
- `WIDTH_PACKET`, 57, packet width in bits; the packet is opaque to this block.
- `NUM_PORTS`, 5, number of requesters; index 0=N, 1=S, 2=E, 3=W, 4=PE.
- `CNT_W`, 16, grant-counter width; used only when `NOC_ARB_STATS_EN` is defined.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `req_valid`  in  NUM_PORTS  per-input packet valid.
- `req_data`  in  NUM_PORTS*WIDTH_PACKET  flattened packets; port i occupies bits [i*WIDTH_PACKET +: WIDTH_PACKET].
- `req_ready`  out  NUM_PORTS  one-hot or zero; accepts the packet from port i this cycle.
- `out_valid`  out  1  output register holds a packet.
- `out_data`  out  WIDTH_PACKET  registered packet.
- `out_src`  out  3  index of the input that supplied `out_data`.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `grant_cnt`  out  NUM_PORTS*CNT_W  per-port grant counters; present only with `NOC_ARB_STATS_EN`.

## Operation
- States:
  - EMPTY: `out_valid`=0.
  - FULL: `out_valid`=1.
- Load condition: `load = (|req_valid) & (~out_valid | out_ready)`.
- Winner selection:
  - Winner = first i with `req_valid[i]`, scanning `ptr`, `ptr+1`, … modulo NUM_PORTS.
  - `ptr` is a 3-bit pointer; it wraps from 4 to 0.
- On `load`:
  - `req_ready[winner]`=1.
  - `out_data`/`out_src` take the winner's packet and index.
  - `out_valid`=1.
  - `ptr` becomes winner+1 modulo NUM_PORTS.
- Without `load`:
  - Every `req_ready` bit is 0.
  - `ptr` is unchanged.
- Transitions:
  - EMPTY→FULL on `load`.
  - FULL→EMPTY on `out_ready & ~|req_valid`.
  - FULL stays FULL on `out_ready & |req_valid`: back-to-back, a new packet replaces the drained one in the same edge.
  - FULL holds on `~out_ready`; `out_data` and `out_src` stay stable.
- `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and `ptr`. Requesters must not make `req_valid` depend on `req_ready`.
- A requester keeps `req_valid` and its data stable until it sees `req_ready`; the arbiter never drops a valid request.
- Fairness: a continuously requesting port is granted within NUM_PORTS loads.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=0, `grant_cnt`=0.
- During reset cycles `req_ready`=0.
- Reset mid-operation discards any held packet; no partial transfer is reported.
- Latency: 1 cycle from the `req_ready` edge to `out_valid`.
- Throughput: 1 packet per cycle while `out_ready`=1.
- If `out_ready`=1 while `out_valid`=0, nothing is transferred; this is not an error.

## Configuration
- `NOC_ARB_STATS_EN` defined:
  - `grant_cnt[i]` increments on each `load` won by port i.
  - It saturates at 2^CNT_W−1.
  - It clears only on reset.
- `NOC_ARB_STATS_EN` undefined:
  - No `grant_cnt` port and no counter flops.
  - Arbitration behaviour is identical.

## Structure
- `noc_pkg` holds:
  - `WIDTH_PACKET`=57 and `NUM_PORTS`=5.
  - A `port_e` enum: N=0, S=1, E=2, W=3, PE=4.
  - The packet typedef `logic [WIDTH_PACKET-1:0]`.
- Sub-module `rr_picker`: purely combinational rotate-priority-rotate.
  - Inputs: `req` and `ptr`.
  - Outputs: one-hot `gnt`, winner index and `any`.
- `noc_port_arbiter` holds the output register, `ptr` and the optional counters.

## Test plan
- Reset, then single request: `rst_n`=0 for 2 cycles, then `req_valid`=5'b00100 with data 57'h1ABC and `out_ready`=1 → `req_ready`=5'b00100 in the same cycle. Next cycle: `out_valid`=1, `out_data`=57'h1ABC, `out_src`=2, `ptr`=3.
- Round-robin: all five request continuously with `out_ready`=1 → `out_src` sequence 0,1,2,3,4,0, one per cycle, no gaps.
- Backpressure: output FULL with `out_src`=1, `out_ready`=0 for 4 cycles while ports 0 and 3 request → `req_ready`=0 and `out_data` stable for those 4 cycles. When `out_ready` rises, port 3 is granted first (`ptr`=2).
- Wrap: `ptr`=4 and `req_valid`=5'b00011 → port 0 granted, `ptr`=1.
- Reset mid-operation: FULL with `out_ready`=0, assert `rst_n`=0 for one edge → `out_valid`=0 and `ptr`=0. The same request re-issued after reset is granted again.
- Stats (`NOC_ARB_STATS_EN`, CNT_W=4): port 4 wins 20 loads → `grant_cnt[4]`=15, other counters 0.
